multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
// Multicycle control unit for the Reverberacion processor datapath. Sequences each instruction
// through FETCH, DECODE, EXEC, MEM and WB states and decodes Op/Inmed/func per state.
// Tracks NZCV flags and evaluates condition codes. Stalls on a ready-handshaked memory port.
// Sits between the instruction register and the datapath muxes, register file, ALU and memory.
// PARAMETERS
// FUNC_W       4   width of the func field; only the low 4 bits are decoded, upper bits must be 0
// ALUCTRL_W    4   width of ALUControl
// MEM_TIMEOUT  15  max cycles waiting on mem_ready before bus_err; >=1
// PORTS
// clk         in   1          rising-edge clock
// rst_n       in   1          asynchronous active-low reset
// Op          in   2          00 data-proc, 01 LDR, 10 STR, 11 B
// Inmed       in   1          1 = immediate operand B
// func        in   FUNC_W     data-proc function (0000 ADD, 0001 SUB, 0010 AND, 0011 ORR, 1001 CMP)
// Cond        in   4          condition field of the current instruction
// ALUFlags    in   4          NZCV from the ALU this cycle
// mem_ready   in   1          memory completes the current access this cycle
// mem_req     out  1          memory access request, held until mem_ready or timeout
// MemWrite    out  1          write strobe, qualifies mem_req
// AdrSrc      out  1          0 = PC, 1 = ALU result as address
// IRWrite     out  1          load instruction register
// PCWrite     out  1          load PC
// RegWrite    out  1          register-file write enable
// ResultSrc   out  2          00 ALUOut, 01 ReadData, 10 ALU direct
// ALUSrcA     out  1          0 = Rn, 1 = PC
// ALUSrcB     out  2          00 Rm, 01 Imm, 10 const 4
// ALUControl  out  ALUCTRL_W  0 ADD, 1 SUB, 2 AND, 3 ORR
// FlagW       out  1          latch ALUFlags into the internal NZCV register
// NoWrite     out  1          ALU result must not be written (CMP)
// RegSrcA1    out  1          read port 1 select: PC (B)
// RegSrcA2    out  1          read port 2 select: Rd (STR)
// bus_err     out  1          one-cycle pulse on memory timeout
// state_o     out  4          current state encoding, for debug
// BEHAVIOUR
// - Reset (async, rst_n=0): state=FETCH, NZCV=0000, wait counter=0. All outputs 0 except mem_req=1 after release.
// - Reset mid-access abandons the access. No partial register or PC write.
// - States and transitions:
//   FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD.
//     On mem_ready: IRWrite=1, PCWrite=1 (PC+4), go to DECODE.
//   DECODE: reads registers; RegSrcA1=(Op==11), RegSrcA2=(Op==10).
//     If the condition fails, go to FETCH.
//     Otherwise: Op=00 -> EXECI if Inmed else EXECR. Op=01/10 -> MEMADR. Op=11 -> BRANCH.
//   EXECR/EXECI: ALUSrcB=00/01; ALUControl from func (CMP->SUB). Go to ALUWB.
//     FlagW=1 for func 1001 and 0001.
//   ALUWB: RegWrite=!NoWrite, ResultSrc=00. Go to FETCH. NoWrite=1 for CMP.
//   MEMADR: ALUSrcB=01 if Inmed else 00, ALUControl=ADD. Op=01 -> MEMRD, Op=10 -> MEMWR.
//   MEMRD: mem_req=1, AdrSrc=1. On mem_ready go to MEMWB.
//   MEMWB: RegWrite=1, ResultSrc=01. Go to FETCH.
//   MEMWR: mem_req=1, MemWrite=1, AdrSrc=1. On mem_ready go to FETCH.
//   BRANCH: ALUSrcA=0 (PC via A1), ALUSrcB=01, ResultSrc=10, PCWrite=1. Go to FETCH.
// - Condition evaluation uses the registered NZCV, not ALUFlags. Codes:
//   0000 EQ, 0001 NE, 0010 CS, 0011 CC, 0100 MI, 0101 PL, 1010 GE, 1011 LT, 1100 GT, 1101 LE, 1110 AL.
//   Any other code evaluates false.
// - NZCV updates on the clock edge ending a cycle with FlagW=1.
// - Illegal func (any code not listed above): treated as NoWrite ADD, no FlagW, normal timing.
// - Wait counter: counts cycles with mem_req=1 and mem_ready=0; clears on ready or state change.
//   On reaching MEM_TIMEOUT: bus_err=1 for one cycle, drop the access, go to FETCH.
//   No write occurs; a fetch retries at the same PC.
// - Latency at mem_ready=1 immediately: data-proc 4, LDR 5, STR 4, branch 3, cond-fail 2 cycles.
// TESTING
// ADD r2,r3,r4 (Op=00,Inmed=0,func=0000,Cond=1110), zero-wait memory
//   -> FETCH,DECODE,EXECR,ALUWB; RegWrite=1 only in ALUWB; back in FETCH at cycle 4.
// CMP r2,#12 (Inmed=1,func=1001), ALUFlags=0100 -> FlagW=1 in EXECI; RegWrite=0 in ALUWB.
//   A following BEQ (Op=11,Cond=0000) takes BRANCH with PCWrite=1.
// LDR r2,[r3] with mem_ready low 3 cycles in MEMRD -> mem_req held 4 cycles; MEMWB RegWrite=1, ResultSrc=01.
// STR with MEM_TIMEOUT=15 and mem_ready never high -> bus_err pulse after 15 wait cycles.
//   MemWrite then drops; state_o=FETCH.
// Cond=0001 (NE) with Z=1 -> DECODE returns to FETCH; no RegWrite, PCWrite or MemWrite.
// rst_n low during MEMWR -> outputs 0 immediately; after release FETCH with mem_req=1, NZCV=0000.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: sequences each instruction through fetch, decode,
// execute, memory and write-back states, decodes Op/Inmed/func into datapath
// controls, keeps an NZCV flag register for conditional execution, and stalls
// on a ready-handshaked memory port with a bounded wait.
module multicycle_control_fsm #(
   parameter int FUNC_W      = 4,
   parameter int ALUCTRL_W   = 4,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [1:0]           Op,
   input  logic                 Inmed,
   input  logic [FUNC_W-1:0]    func,
   input  logic [3:0]           Cond,
   input  logic [3:0]           ALUFlags,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 MemWrite,
   output logic                 AdrSrc,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 RegWrite,
   output logic [1:0]           ResultSrc,
   output logic                 ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [ALUCTRL_W-1:0] ALUControl,
   output logic                 FlagW,
   output logic                 NoWrite,
   output logic                 RegSrcA1,
   output logic                 RegSrcA2,
   output logic                 bus_err,
   output logic [3:0]           state_o
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_CNT = CW'(MEM_TIMEOUT);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXECR  = 4'd2,
      S_EXECI  = 4'd3,
      S_ALUWB  = 4'd4,
      S_MEMADR = 4'd5,
      S_MEMRD  = 4'd6,
      S_MEMWB  = 4'd7,
      S_MEMWR  = 4'd8,
      S_BRANCH = 4'd9
   } state_t;

   state_t        state, state_nx;
   logic [3:0]    nzcv;
   logic [CW-1:0] wait_cnt;
   logic          access;
   logic          timeout;
   logic          cond_ok;
   logic          func_hi;
   logic [3:0]    alu_code;
   logic          dp_flagw;
   logic          dp_nowrite;

   // Data-processing function decode; anything unlisted becomes a silent ADD.
   always_comb begin
      alu_code   = 4'd0;
      dp_flagw   = 1'b0;
      dp_nowrite = 1'b0;
      func_hi    = |(func >> 4);
      case (func[3:0])
         4'b0000: alu_code = 4'd0;
         4'b0001: begin alu_code = 4'd1; dp_flagw = 1'b1; end
         4'b0010: alu_code = 4'd2;
         4'b0011: alu_code = 4'd3;
         4'b1001: begin alu_code = 4'd1; dp_flagw = 1'b1; dp_nowrite = 1'b1; end
         default: dp_nowrite = 1'b1;
      endcase
      if (func_hi) begin
         alu_code   = 4'd0;
         dp_flagw   = 1'b0;
         dp_nowrite = 1'b1;
      end
   end

   // Condition check against the registered flags (N=3, Z=2, C=1, V=0).
   always_comb begin
      case (Cond)
         4'b0000: cond_ok = nzcv[2];
         4'b0001: cond_ok = !nzcv[2];
         4'b0010: cond_ok = nzcv[1];
         4'b0011: cond_ok = !nzcv[1];
         4'b0100: cond_ok = nzcv[3];
         4'b0101: cond_ok = !nzcv[3];
         4'b1010: cond_ok = (nzcv[3] == nzcv[0]);
         4'b1011: cond_ok = (nzcv[3] != nzcv[0]);
         4'b1100: cond_ok = !nzcv[2] && (nzcv[3] == nzcv[0]);
         4'b1101: cond_ok = nzcv[2] || (nzcv[3] != nzcv[0]);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   assign access  = rst_n && (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
   assign timeout = access && (wait_cnt == TIMEOUT_CNT);
   assign state_o = state;

   // Next-state and control outputs; everything is held low while in reset.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      state_nx   = state;
      mem_req    = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = '0;
      FlagW      = 1'b0;
      NoWrite    = 1'b0;
      RegSrcA1   = 1'b0;
      RegSrcA2   = 1'b0;
      bus_err    = 1'b0;
      if (rst_n) begin
         case (state)
            S_FETCH: begin
               mem_req = !timeout;
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               bus_err = timeout;
               if (!timeout && mem_ready) begin
                  IRWrite  = 1'b1;
                  PCWrite  = 1'b1;
                  state_nx = S_DECODE;
               end
            end
            S_DECODE: begin
               RegSrcA1 = (Op == 2'b11);
               RegSrcA2 = (Op == 2'b10);
               if (!cond_ok)           state_nx = S_FETCH;
               else if (Op == 2'b00)   state_nx = Inmed ? S_EXECI : S_EXECR;
               else if (Op == 2'b11)   state_nx = S_BRANCH;
               else                    state_nx = S_MEMADR;
            end
            S_EXECR, S_EXECI: begin
               ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
               ALUControl = ALUCTRL_W'(alu_code);
               FlagW      = dp_flagw;
               NoWrite    = dp_nowrite;
               state_nx   = S_ALUWB;
            end
            S_ALUWB: begin
               NoWrite  = dp_nowrite;
               RegWrite = !dp_nowrite;
               state_nx = S_FETCH;
            end
            S_MEMADR: begin
               ALUSrcB  = {1'b0, Inmed};
               state_nx = (Op == 2'b01) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               mem_req = !timeout;
               AdrSrc  = 1'b1;
               bus_err = timeout;
               if (timeout)        state_nx = S_FETCH;
               else if (mem_ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
               RegWrite  = 1'b1;
               ResultSrc = 2'b01;
               state_nx  = S_FETCH;
            end
            S_MEMWR: begin
               mem_req  = !timeout;
               MemWrite = !timeout;
               AdrSrc   = 1'b1;
               bus_err  = timeout;
               if (timeout || mem_ready) state_nx = S_FETCH;
            end
            S_BRANCH: begin
               ALUSrcB   = 2'b01;
               ResultSrc = 2'b10;
               PCWrite   = 1'b1;
               state_nx  = S_FETCH;
            end
            default: state_nx = S_FETCH;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (!rst_n) state <= S_FETCH;
      else        state <= state_nx;
   end

   // NZCV register, loaded from the ALU when the execute step asks for it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     nzcv <= 4'b0000;
      else if (FlagW) nzcv <= ALUFlags;
   end

   // Memory wait counter; restarts on completion, timeout or any state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                         wait_cnt <= '0;
      else if (timeout || mem_ready || state_nx != state) wait_cnt <= '0;
      else if (access)                                    wait_cnt <= wait_cnt + CW'(1);
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: each instruction is expanded
// by a reference model into the cycle-by-cycle control pattern it should
// produce, memory wait/ready is driven from that plan, and the DUT is compared
// every cycle.
module tb_multicycle_control_fsm;

   localparam int TMO = 15;

   localparam logic [3:0] ST_FETCH  = 4'd0;
   localparam logic [3:0] ST_DECODE = 4'd1;
   localparam logic [3:0] ST_EXECR  = 4'd2;
   localparam logic [3:0] ST_EXECI  = 4'd3;
   localparam logic [3:0] ST_ALUWB  = 4'd4;
   localparam logic [3:0] ST_MEMADR = 4'd5;
   localparam logic [3:0] ST_MEMRD  = 4'd6;
   localparam logic [3:0] ST_MEMWB  = 4'd7;
   localparam logic [3:0] ST_MEMWR  = 4'd8;
   localparam logic [3:0] ST_BRANCH = 4'd9;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       adr_src;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_control;
      logic       flag_w;
      logic       no_write;
      logic       reg_src_a1;
      logic       reg_src_a2;
      logic       bus_err;
   } ctl_t;

   typedef struct {
      logic [1:0] op;
      logic       inmed;
      logic [3:0] func;
      logic [3:0] cond;
      logic [3:0] flags;
      int         wf;
      int         wm;
   } instr_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] Op;
   logic       Inmed;
   logic [3:0] func;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic       mem_ready;
   logic       mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
   logic [1:0] ResultSrc;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [3:0] ALUControl;
   logic       FlagW, NoWrite, RegSrcA1, RegSrcA2, bus_err;
   logic [3:0] state_o;

   int checks = 0;
   int errors = 0;

   logic [3:0] m_nzcv;
   logic [3:0] pq_state[$];
   logic       pq_ready[$];
   ctl_t       pq_ctl[$];

   multicycle_control_fsm #(.FUNC_W(4), .ALUCTRL_W(4), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .Op(Op), .Inmed(Inmed), .func(func), .Cond(Cond),
      .ALUFlags(ALUFlags), .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite),
      .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
      .FlagW(FlagW), .NoWrite(NoWrite), .RegSrcA1(RegSrcA1), .RegSrcA2(RegSrcA2),
      .bus_err(bus_err), .state_o(state_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired got=running exp=finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic ctl_t dut_ctl();
      return {mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc, ALUSrcA,
              ALUSrcB, ALUControl, FlagW, NoWrite, RegSrcA1, RegSrcA2, bus_err};
   endfunction

   // Condition codes evaluated on the model's flags.
   function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cy;
         4'd3:  return !cy;
         4'd4:  return n;
         4'd5:  return !n;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic push(input logic [3:0] st, input logic rdy, input ctl_t c);
      pq_state.push_back(st);
      pq_ready.push_back(rdy);
      pq_ctl.push_back(c);
   endtask

   // Memory access of w wait cycles (w >= TMO means the memory never answers).
   // Returns 1 if it completed, 0 on timeout.
   task automatic push_access(input logic [3:0] st, input int w, input ctl_t base,
                              input ctl_t done_c, output bit ok);
      ctl_t t;
      int n = (w < TMO) ? w : TMO;
      for (int k = 0; k < n; k++) push(st, 1'b0, base);
      if (w >= TMO) begin
         t = base;
         t.mem_req   = 1'b0;
         t.mem_write = 1'b0;
         t.bus_err   = 1'b1;
         push(st, 1'b0, t);
         ok = 1'b0;
      end else begin
         push(st, 1'b1, done_c);
         ok = 1'b1;
      end
   endtask

   // Expand one instruction into its expected per-cycle behaviour.
   task automatic build_plan(input instr_t in);
      ctl_t c, d;
      bit ok;
      int w = in.wf;
      logic [3:0] alu;
      bit fw, nw;
      pq_state.delete();
      pq_ready.delete();
      pq_ctl.delete();
      c = '0;
      c.mem_req   = 1'b1;
      c.alu_src_a = 1'b1;
      c.alu_src_b = 2'b10;
      d = c;
      d.ir_write = 1'b1;
      d.pc_write = 1'b1;
      ok = 1'b0;
      while (!ok) begin
         push_access(ST_FETCH, w, c, d, ok);
         w = 0;
      end
      c = '0;
      c.reg_src_a1 = (in.op == 2'b11);
      c.reg_src_a2 = (in.op == 2'b10);
      push(ST_DECODE, 1'b0, c);
      if (!cond_holds(in.cond, m_nzcv)) return;
      case (in.op)
         2'b00: begin
            alu = 4'd0; fw = 1'b0; nw = 1'b0;
            case (in.func)
               4'd0: ;
               4'd1: begin alu = 4'd1; fw = 1'b1; end
               4'd2: alu = 4'd2;
               4'd3: alu = 4'd3;
               4'd9: begin alu = 4'd1; fw = 1'b1; nw = 1'b1; end
               default: nw = 1'b1;
            endcase
            c = '0;
            c.alu_src_b   = in.inmed ? 2'b01 : 2'b00;
            c.alu_control = alu;
            c.flag_w      = fw;
            c.no_write    = nw;
            push(in.inmed ? ST_EXECI : ST_EXECR, 1'b0, c);
            if (fw) m_nzcv = in.flags;
            c = '0;
            c.no_write  = nw;
            c.reg_write = !nw;
            push(ST_ALUWB, 1'b0, c);
         end
         2'b01, 2'b10: begin
            c = '0;
            c.alu_src_b = {1'b0, in.inmed};
            push(ST_MEMADR, 1'b0, c);
            c = '0;
            c.mem_req   = 1'b1;
            c.adr_src   = 1'b1;
            c.mem_write = (in.op == 2'b10);
            push_access((in.op == 2'b01) ? ST_MEMRD : ST_MEMWR, in.wm, c, c, ok);
            if (ok && in.op == 2'b01) begin
               c = '0;
               c.reg_write  = 1'b1;
               c.result_src = 2'b01;
               push(ST_MEMWB, 1'b0, c);
            end
         end
         default: begin
            c = '0;
            c.alu_src_b  = 2'b01;
            c.result_src = 2'b10;
            c.pc_write   = 1'b1;
            push(ST_BRANCH, 1'b0, c);
         end
      endcase
   endtask

   // Release reset just after a rising edge so the first fetch starts clean.
   task automatic release_reset();
      ctl_t f = '0;
      f.mem_req   = 1'b1;
      f.alu_src_a = 1'b1;
      f.alu_src_b = 2'b10;
      @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      check("post_rst_state", 32'(state_o), 32'(ST_FETCH));
      check("post_rst_ctl", 32'(dut_ctl()), 32'(f));
      m_nzcv = 4'b0000;
   endtask

   // Drive one instruction through the DUT; optionally reset at plan step abort_at.
   task automatic run_instr(input instr_t in, input int abort_at);
      build_plan(in);
      for (int i = 0; i < pq_state.size(); i++) begin
         @(negedge clk);
         Op = in.op; Inmed = in.inmed; func = in.func; Cond = in.cond;
         ALUFlags = in.flags; mem_ready = pq_ready[i];
         #1;
         check("state", 32'(state_o), 32'(pq_state[i]));
         check("ctl", 32'(dut_ctl()), 32'(pq_ctl[i]));
         if (i == abort_at) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_ctl", 32'(dut_ctl()), 32'h0);
            check("rst_state", 32'(state_o), 32'(ST_FETCH));
            mem_ready = 1'b0;
            release_reset();
            return;
         end
      end
   endtask

   function automatic instr_t mk(input logic [1:0] op, input logic inmed, input logic [3:0] fn,
                                 input logic [3:0] cond, input logic [3:0] flags,
                                 input int wf, input int wm);
      instr_t r;
      r.op = op; r.inmed = inmed; r.func = fn; r.cond = cond; r.flags = flags;
      r.wf = wf; r.wm = wm;
      return r;
   endfunction

   function automatic int rand_wait();
      return ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3));
   endfunction

   initial begin
      instr_t in;
      logic [3:0] fsel[8];
      fsel = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd9, 4'd9, 4'd5, 4'd15};
      rst_n = 1'b0; Op = 2'b00; Inmed = 1'b0; func = 4'd0; Cond = 4'd14;
      ALUFlags = 4'd0; mem_ready = 1'b0;
      #3;
      check("reset_ctl", 32'(dut_ctl()), 32'h0);
      check("reset_state", 32'(state_o), 32'(ST_FETCH));
      release_reset();

      // ADD r2,r3,r4 with zero-wait memory.
      run_instr(mk(2'b00, 1'b0, 4'd0, 4'd14, 4'b0000, 0, 0), -1);
      // CMP r2,#12 producing Z, then BEQ taken.
      run_instr(mk(2'b00, 1'b1, 4'd9, 4'd14, 4'b0100, 0, 0), -1);
      run_instr(mk(2'b11, 1'b0, 4'd0, 4'd0, 4'b0000, 0, 0), -1);
      // NE with Z set: squashed in decode.
      run_instr(mk(2'b00, 1'b0, 4'd0, 4'd1, 4'b0000, 0, 0), -1);
      // LDR with three wait cycles.
      run_instr(mk(2'b01, 1'b0, 4'd0, 4'd14, 4'b0000, 0, 3), -1);
      // STR whose memory never answers.
      run_instr(mk(2'b10, 1'b0, 4'd0, 4'd14, 4'b0000, 0, 20), -1);
      // Fetch timeout followed by retry.
      run_instr(mk(2'b00, 1'b0, 4'd2, 4'd14, 4'b0000, 20, 0), -1);
      // Reset in the middle of a stalled store.
      run_instr(mk(2'b10, 1'b1, 4'd0, 4'd14, 4'b0000, 0, 6), 4);
      // Flags cleared by reset: EQ fails, NE executes.
      run_instr(mk(2'b00, 1'b0, 4'd0, 4'd0, 4'b0000, 0, 0), -1);
      run_instr(mk(2'b00, 1'b0, 4'd0, 4'd1, 4'b0000, 0, 0), -1);

      for (int n = 0; n < 300; n++) begin
         in.op    = 2'($urandom_range(0, 3));
         in.inmed = 1'($urandom_range(0, 1));
         in.func  = fsel[$urandom_range(0, 7)];
         in.cond  = ($urandom_range(0, 1) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
         in.flags = 4'($urandom_range(0, 15));
         in.wf    = rand_wait();
         in.wm    = rand_wait();
         run_instr(in, -1);
      end

      // The instruction stream must always return to fetch.
      @(negedge clk);
      #1;
      check("final_state", 32'(state_o), 32'(ST_FETCH));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
